vibration_stats: RTL

- Downstream consumer of the accelerometer driver's sample stream (8-bit signed axis value plus its o_sync strobe).
- Groups samples into fixed windows of 2^WIN_LOG2 samples and publishes per-window statistics: min, max, peak-to-peak, mean, and mean absolute value.
- Raises a sticky vibration alarm when peak-to-peak reaches a threshold.
- Feeds the display/report logic with one result set per window.

---
 rtl/vibration_stats.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vibration_stats.sv
// Per-window statistics over the accelerometer sample stream:
// min, max, peak-to-peak, floor mean, mean |x|, window count, sticky alarm.
module vibration_stats #(
  parameter int         WIN_LOG2  = 8,
  parameter int         SKIP_N    = 4,
  parameter logic [7:0] ALARM_P2P = 8'd64
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        stats_enable,
  input  logic        sample_sync,
  input  logic [7:0]  sample_data,
  input  logic        alarm_clr,
  output logic        result_valid,
  output logic [7:0]  win_min,
  output logic [7:0]  win_max,
  output logic [7:0]  win_p2p,
  output logic [7:0]  win_mean,
  output logic [7:0]  win_mean_abs,
  output logic [15:0] win_count,
  output logic        alarm
);

  localparam int AW = 8 + WIN_LOG2;
  localparam int SW = (SKIP_N > 1) ? $clog2(SKIP_N) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SKIP  = 2'd1;
  localparam logic [1:0] ACCUM = 2'd2;

  localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP_N - 1);
  localparam logic [WIN_LOG2-1:0] IDX_LAST = '1;

  localparam logic signed [7:0] MIN_INIT = 8'sd127;
  localparam logic signed [7:0] MAX_INIT = -8'sd128;

  logic [1:0]           state;
  logic                 sync_prev;
  logic [SW-1:0]        skip_cnt;
  logic [WIN_LOG2-1:0]  idx;
  logic signed [7:0]    acc_min;
  logic signed [7:0]    acc_max;
  logic signed [AW-1:0] acc_sum;
  logic [AW-1:0]        acc_abs;

  logic                 accept;
  logic                 last;
  logic                 publish;
  logic                 acc_clr;
  logic                 acc_upd;
  logic signed [7:0]    x;
  logic [7:0]           x_abs;
  logic signed [7:0]    nxt_min;
  logic signed [7:0]    nxt_max;
  logic signed [AW-1:0] nxt_sum;
  logic [AW-1:0]        nxt_abs;
  logic [7:0]           nxt_p2p;

  assign accept = sample_sync & ~sync_prev;
  assign last   = (idx == IDX_LAST);
  assign x      = sample_data;
  assign x_abs  = sample_data[7] ? (~sample_data + 8'd1) : sample_data;

  assign nxt_min = (x < acc_min) ? x : acc_min;
  assign nxt_max = (x > acc_max) ? x : acc_max;
  assign nxt_sum = acc_sum + $signed({{WIN_LOG2{x[7]}}, x});
  assign nxt_abs = acc_abs + {{WIN_LOG2{1'b0}}, x_abs};
  // 8-bit modular difference is exact since max >= min
  assign nxt_p2p = nxt_max - nxt_min;

  // The last sample publishes even if enable drops on that same edge
  assign publish = (state == ACCUM) && accept && last;

  assign acc_clr = !stats_enable || (state != ACCUM) || publish;
  assign acc_upd = (state == ACCUM) && accept;

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      sync_prev <= 1'b0;
    end else begin
      sync_prev <= sample_sync;
    end
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else if (!stats_enable) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          skip_cnt <= '0;
          state    <= (SKIP_N == 0) ? ACCUM : SKIP;
        end
        SKIP: begin
          if (accept) begin
            if (skip_cnt == SKIP_LAST) begin
              state <= ACCUM;
            end else begin
              skip_cnt <= skip_cnt + 1'b1;
            end
          end
        end
        ACCUM: state <= ACCUM;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      acc_min <= MIN_INIT;
      acc_max <= MAX_INIT;
      acc_sum <= '0;
      acc_abs <= '0;
    end else if (acc_clr) begin
      idx     <= '0;
      acc_min <= MIN_INIT;
      acc_max <= MAX_INIT;
      acc_sum <= '0;
      acc_abs <= '0;
    end else if (acc_upd) begin
      idx     <= idx + 1'b1;
      acc_min <= nxt_min;
      acc_max <= nxt_max;
      acc_sum <= nxt_sum;
      acc_abs <= nxt_abs;
    end
  end

  // Floor shift of the window sum is just its upper byte
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      result_valid <= 1'b0;
      win_min      <= '0;
      win_max      <= '0;
      win_p2p      <= '0;
      win_mean     <= '0;
      win_mean_abs <= '0;
      win_count    <= '0;
    end else begin
      result_valid <= publish;
      if (publish) begin
        win_min      <= nxt_min;
        win_max      <= nxt_max;
        win_p2p      <= nxt_p2p;
        win_mean     <= nxt_sum[WIN_LOG2 +: 8];
        win_mean_abs <= nxt_abs[WIN_LOG2 +: 8];
        win_count    <= win_count + 16'd1;
      end
    end
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      alarm <= 1'b0;
    end else if (publish && (nxt_p2p >= ALARM_P2P)) begin
      alarm <= 1'b1;
    end else if (alarm_clr) begin
      alarm <= 1'b0;
    end
  end

endmodule
